// File: rtl/phys_reg_file_rdy_pkg.sv
// Shared sizing and types for the physical register file slice.
package phys_reg_file_rdy_pkg;

  localparam int NUM_PREGS = 64;
  localparam int XLEN      = 32;
  localparam int NUM_FUS   = 2;

  typedef logic [$clog2(NUM_PREGS)-1:0] preg_idx_t;
  typedef logic [XLEN-1:0]              xlen_t;

  function automatic logic even_parity(input xlen_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/phys_reg_file_rdy_bypass_mux.sv
// Per-read-port operand select: preg 0, then same-cycle writeback, then stored entry.
module phys_reg_file_rdy_bypass_mux
  import phys_reg_file_rdy_pkg::*;
#(
  parameter int PW           = 6,
  parameter int XLEN         = 32,
  parameter int NUM_WR_PORTS = 2
) (
  input  logic [PW-1:0]                rd_preg_i,
  input  logic [XLEN-1:0]              stored_data_i,
  input  logic                         stored_ready_i,
  input  logic                         stored_par_err_i,
  input  logic [NUM_WR_PORTS-1:0]      wr_en_i,
  input  logic [NUM_WR_PORTS*PW-1:0]   wr_preg_i,
  input  logic [NUM_WR_PORTS*XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0]              rd_data_o,
  output logic                         rd_ready_o,
  output logic                         rd_par_err_o
);

  logic hit;

  always_comb begin
    rd_data_o  = stored_data_i;
    rd_ready_o = stored_ready_i;
    hit        = 1'b0;
    // Ascending scan so the highest-numbered matching write port wins.
    for (int i = 0; i < NUM_WR_PORTS; i++) begin
      if (wr_en_i[i] && (wr_preg_i[i*PW +: PW] == rd_preg_i)) begin
        rd_data_o  = wr_data_i[i*XLEN +: XLEN];
        rd_ready_o = 1'b1;
        hit        = 1'b1;
      end
    end
    if (rd_preg_i == '0) begin
      rd_data_o  = '0;
      rd_ready_o = 1'b1;
    end
    rd_par_err_o = stored_par_err_i && !hit && (rd_preg_i != '0);
  end

endmodule

// File: rtl/phys_reg_file_rdy.sv
// Physical register file with per-preg ready bits, write bypass and flush restore.
// Optional per-entry even parity with read-side checking under `PRF_PARITY_EN.
module phys_reg_file_rdy #(
  parameter int  NUM_PREGS    = phys_reg_file_rdy_pkg::NUM_PREGS,
  parameter int  XLEN         = phys_reg_file_rdy_pkg::XLEN,
  parameter int  NUM_RD_PORTS = 2 * phys_reg_file_rdy_pkg::NUM_FUS,
  parameter int  NUM_WR_PORTS = phys_reg_file_rdy_pkg::NUM_FUS,
  parameter int  NUM_ALLOC    = 2,
  localparam int PW           = $clog2(NUM_PREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD_PORTS*PW-1:0]   rd_preg,
  output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]      rd_ready,
  input  logic [NUM_WR_PORTS-1:0]      wr_valid,
  input  logic [NUM_WR_PORTS*PW-1:0]   wr_preg,
  input  logic [NUM_WR_PORTS*XLEN-1:0] wr_data,
  input  logic [NUM_ALLOC-1:0]         alloc_valid,
  input  logic [NUM_ALLOC*PW-1:0]      alloc_preg,
  input  logic                         flush,
  output logic                         wr_conflict,
  output logic [NUM_RD_PORTS-1:0]      rd_par_err
);
  import phys_reg_file_rdy_pkg::*;

  logic [XLEN-1:0]         data_q [NUM_PREGS];
  logic [XLEN-1:0]         data_d [NUM_PREGS];
  logic [NUM_PREGS-1:0]    rdy_q, rdy_d;
  logic                    conflict_q, conflict_d;
  logic [NUM_WR_PORTS-1:0] wr_en;
`ifdef PRF_PARITY_EN
  logic [NUM_PREGS-1:0]    par_q, par_d;
`endif

  // Only matters when NUM_PREGS is not a power of two.
  function automatic logic in_range(input logic [PW-1:0] p);
    return int'(p) < NUM_PREGS;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_WR_PORTS; i++)
      wr_en[i] = wr_valid[i] && (wr_preg[i*PW +: PW] != '0) && in_range(wr_preg[i*PW +: PW]);
  end

  always_comb begin
    data_d     = data_q;
    rdy_d      = rdy_q;
    conflict_d = 1'b0;
`ifdef PRF_PARITY_EN
    par_d      = par_q;
`endif
    for (int i = 0; i < NUM_WR_PORTS; i++) begin
      if (wr_en[i]) begin
        data_d[wr_preg[i*PW +: PW]] = wr_data[i*XLEN +: XLEN];
        rdy_d[wr_preg[i*PW +: PW]]  = 1'b1;
`ifdef PRF_PARITY_EN
        par_d[wr_preg[i*PW +: PW]]  = ^wr_data[i*XLEN +: XLEN];
`endif
      end
      for (int k = i + 1; k < NUM_WR_PORTS; k++)
        if (wr_en[i] && wr_en[k] && (wr_preg[i*PW +: PW] == wr_preg[k*PW +: PW]))
          conflict_d = 1'b1;
    end
    // Alloc after writeback so a same-cycle alloc leaves the preg not ready.
    for (int j = 0; j < NUM_ALLOC; j++)
      if (alloc_valid[j] && (alloc_preg[j*PW +: PW] != '0) && in_range(alloc_preg[j*PW +: PW]))
        rdy_d[alloc_preg[j*PW +: PW]] = 1'b0;
    if (flush) rdy_d = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PREGS; p++) data_q[p] <= '0;
      rdy_q      <= '1;
      conflict_q <= 1'b0;
`ifdef PRF_PARITY_EN
      par_q      <= '0;
`endif
    end else begin
      data_q     <= data_d;
      rdy_q      <= rdy_d;
      conflict_q <= conflict_d;
`ifdef PRF_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign wr_conflict = conflict_q;

  for (genvar r = 0; r < NUM_RD_PORTS; r++) begin : g_rd
    logic [PW-1:0]   idx;
    logic [XLEN-1:0] st_data;
    logic            st_rdy;
    logic            st_perr;

    assign idx     = rd_preg[r*PW +: PW];
    assign st_data = in_range(idx) ? data_q[idx] : '0;
    assign st_rdy  = in_range(idx) ? rdy_q[idx] : 1'b1;
`ifdef PRF_PARITY_EN
    assign st_perr = in_range(idx) && (par_q[idx] != ^data_q[idx]);
`else
    assign st_perr = 1'b0;
`endif

    phys_reg_file_rdy_bypass_mux #(
      .PW           (PW),
      .XLEN         (XLEN),
      .NUM_WR_PORTS (NUM_WR_PORTS)
    ) u_prf_bypass_mux (
      .rd_preg_i        (idx),
      .stored_data_i    (st_data),
      .stored_ready_i   (st_rdy),
      .stored_par_err_i (st_perr),
      .wr_en_i          (wr_en),
      .wr_preg_i        (wr_preg),
      .wr_data_i        (wr_data),
      .rd_data_o        (rd_data[r*XLEN +: XLEN]),
      .rd_ready_o       (rd_ready[r]),
      .rd_par_err_o     (rd_par_err[r])
    );
  end

endmodule

// File: tb/tb_phys_reg_file_rdy.sv
// Randomised and directed bench for phys_reg_file_rdy with a queue-based scoreboard.
module tb_phys_reg_file_rdy;
  import phys_reg_file_rdy_pkg::*;

  localparam int NP  = 64;
  localparam int XL  = 32;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int NAL = 2;
  localparam int PW  = 6;
  localparam int W   = NRD*XL + NRD + 1 + NRD;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic [NRD*PW-1:0]  rd_preg;
  logic [NRD*XL-1:0]  rd_data;
  logic [NRD-1:0]     rd_ready;
  logic [NWR-1:0]     wr_valid;
  logic [NWR*PW-1:0]  wr_preg;
  logic [NWR*XL-1:0]  wr_data;
  logic [NAL-1:0]     alloc_valid;
  logic [NAL*PW-1:0]  alloc_preg;
  logic               flush;
  logic               wr_conflict;
  logic [NRD-1:0]     rd_par_err;

  always #5 clk = ~clk;

  phys_reg_file_rdy #(
    .NUM_PREGS(NP), .XLEN(XL), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR), .NUM_ALLOC(NAL)
  ) dut (
    .clk(clk), .rst(rst), .rd_preg(rd_preg), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_valid(wr_valid), .wr_preg(wr_preg), .wr_data(wr_data),
    .alloc_valid(alloc_valid), .alloc_preg(alloc_preg), .flush(flush),
    .wr_conflict(wr_conflict), .rd_par_err(rd_par_err)
  );

  // ---------------- reference model ----------------
  logic [XL-1:0] m_data [NP];
  bit            m_rdy  [NP];
  bit            m_conf;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_data[p] = '0;
      m_rdy[p]  = 1'b1;
    end
    m_conf = 1'b0;
  endtask

  // Called at posedge+1 once inputs are applied: predicts this cycle's outputs,
  // queues them, advances the model across the next edge, then waits for it.
  task automatic cycle();
    logic [NRD*XL-1:0] ed;
    logic [NRD-1:0]    er;
    bit                written [NP];
    bit                new_conf;
    int                p, hit;
    if (rst) model_reset();
    for (int r = 0; r < NRD; r++) begin
      p = int'(rd_preg[r*PW +: PW]);
      if (p == 0) begin
        ed[r*XL +: XL] = '0;
        er[r]          = 1'b1;
      end else begin
        hit = -1;
        for (int i = 0; i < NWR; i++)
          if (wr_valid[i] && int'(wr_preg[i*PW +: PW]) == p) hit = i;
        ed[r*XL +: XL] = (hit >= 0) ? wr_data[hit*XL +: XL] : m_data[p];
        er[r]          = (hit >= 0) ? 1'b1 : m_rdy[p];
      end
    end
    exp_q.push_back({ed, er, m_conf, {NRD{1'b0}}});
    if (!rst) begin
      new_conf = 1'b0;
      for (int q = 0; q < NP; q++) written[q] = 1'b0;
      // Highest port first: a later lower port on the same preg only flags a conflict.
      for (int i = NWR - 1; i >= 0; i--) begin
        p = int'(wr_preg[i*PW +: PW]);
        if (wr_valid[i] && p != 0) begin
          if (written[p]) new_conf = 1'b1;
          else begin
            m_data[p]  = wr_data[i*XL +: XL];
            m_rdy[p]   = 1'b1;
            written[p] = 1'b1;
          end
        end
      end
      for (int j = 0; j < NAL; j++) begin
        p = int'(alloc_preg[j*PW +: PW]);
        if (alloc_valid[j] && p != 0) m_rdy[p] = 1'b0;
      end
      if (flush) for (int q = 0; q < NP; q++) m_rdy[q] = 1'b1;
      m_conf = new_conf;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic clear_inputs();
    rd_preg = '0; wr_valid = '0; wr_preg = '0; wr_data = '0;
    alloc_valid = '0; alloc_preg = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int r, input int p);
    rd_preg[r*PW +: PW] = preg_idx_t'(p);
  endtask

  task automatic set_wr(input int i, input int p, input logic [XL-1:0] d);
    wr_valid[i] = 1'b1;
    wr_preg[i*PW +: PW] = preg_idx_t'(p);
    wr_data[i*XL +: XL] = d;
  endtask

  task automatic set_alloc(input int j, input int p);
    alloc_valid[j] = 1'b1;
    alloc_preg[j*PW +: PW] = preg_idx_t'(p);
  endtask

  function automatic int rand_preg();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 0;
    if (k == 1) return NP - 1;
    return $urandom_range(1, 15);
  endfunction

  task automatic random_inputs();
    clear_inputs();
    for (int r = 0; r < NRD; r++) set_rd(r, rand_preg());
    for (int i = 0; i < NWR; i++)
      if ($urandom_range(0, 1) == 1) set_wr(i, rand_preg(), xlen_t'($urandom));
    for (int j = 0; j < NAL; j++)
      if ($urandom_range(0, 2) == 0) set_alloc(j, rand_preg());
    flush = ($urandom_range(0, 19) == 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data",     128'(rd_data),     128'(e[W-1 -: NRD*XL]));
        chk("rd_ready",    128'(rd_ready),    128'(e[2*NRD : NRD+1]));
        chk("wr_conflict", 128'(wr_conflict), 128'(e[NRD]));
        chk("rd_par_err",  128'(rd_par_err),  128'(e[NRD-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    set_rd(0, 0); set_rd(1, 5); set_rd(2, 63);
    cycle();
    cycle();
    rst = 1'b0;

    clear_inputs(); set_rd(0, 0); set_rd(1, 5); set_rd(2, 63); set_rd(3, 1);
    #1;
    chk("reset_rd_data",  128'(rd_data), 128'(0));
    chk("reset_rd_ready", 128'(rd_ready), 128'(4'hF));
    chk("reset_conflict", 128'(wr_conflict), 128'(0));
    cycle();

    clear_inputs(); set_alloc(0, 7); set_rd(0, 7);
    #1 chk("alloc_same_cycle_ready", 128'(rd_ready[0]), 128'(1));
    cycle();
    clear_inputs(); set_rd(0, 7);
    #1 chk("alloc_ready_cleared", 128'(rd_ready[0]), 128'(0));
    cycle();
    clear_inputs(); set_wr(0, 7, 32'd12); set_rd(0, 7);
    #1 chk("bypass_data", 128'(rd_data[31:0]), 128'(12));
    chk("bypass_ready", 128'(rd_ready[0]), 128'(1));
    cycle();
    clear_inputs(); set_rd(0, 7);
    #1 chk("stored_data_7", 128'(rd_data[31:0]), 128'(12));
    cycle();

    clear_inputs(); set_wr(0, 9, 32'hAAAA); set_wr(1, 9, 32'h5555);
    cycle();
    clear_inputs(); set_rd(0, 9);
    #1 chk("conflict_set", 128'(wr_conflict), 128'(1));
    chk("conflict_winner", 128'(rd_data[31:0]), 128'(32'h5555));
    cycle();
    clear_inputs();
    #1 chk("conflict_clear", 128'(wr_conflict), 128'(0));
    cycle();

    clear_inputs(); set_wr(0, 0, 32'hDEAD); set_alloc(0, 0);
    cycle();
    clear_inputs(); set_rd(0, 0); set_rd(1, 0);
    #1 chk("preg0_data", 128'(rd_data[63:0]), 128'(0));
    chk("preg0_ready", 128'(rd_ready[1:0]), 128'(2'b11));
    cycle();

    clear_inputs(); set_alloc(0, 10); set_alloc(1, 11);
    cycle();
    clear_inputs(); set_rd(0, 10); set_rd(1, 11); set_alloc(0, 12); flush = 1'b1;
    #1 chk("pre_flush_ready", 128'(rd_ready[1:0]), 128'(2'b00));
    cycle();
    clear_inputs(); set_rd(0, 10); set_rd(1, 11); set_rd(2, 12);
    #1 chk("post_flush_ready", 128'(rd_ready[2:0]), 128'(3'b111));
    cycle();

`ifdef PRF_PARITY_EN
    clear_inputs(); set_wr(0, 3, 32'h1); set_wr(1, 4, 32'h3);
    cycle();
    clear_inputs(); set_rd(0, 3); set_rd(1, 4);
    force dut.data_q[3] = 32'h11;
    #1 chk("parity_err", 128'(rd_par_err[1:0]), 128'(2'b01));
    release dut.data_q[3];
    @(posedge clk); #1;
    clear_inputs(); set_wr(0, 3, 32'h1);
    cycle();
`endif

    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        clear_inputs();
        for (int r = 0; r < NRD; r++) set_rd(r, rand_preg());
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
      random_inputs();
      cycle();
    end

    clear_inputs();
    #20;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
